memory_arbiter_multiport: RTL and testbench
===========================================

# memory_arbiter_multiport

Round-robin arbiter that connects N_REQ memory readers (engine/station blocks plus the coprocessor control unit) to N_PORTS independent memory read ports. It replaces the single-port N:1 memory arbiter used in the engine topologies, so that grids with many engines can use banked or replicated instruction memory. Each port runs its own round-robin grant and holds that grant until the memory completes the access. Data from each port is routed only to the requester that owns the port.

## Interface
- N_REQ, 5: number of requesters (≥1)
- N_PORTS, 2: number of memory ports (≥1; must be a power of 2 when PORT_MODE=0)
- MEMORY_ADDR_WIDTH, 11: address width
- MEMORY_WIDTH, 16: data width
- PORT_MODE, 0: 0 = banked (port = addr[PB-1:0], where PB = clog2(N_PORTS)); 1 = replicated (any free port serves any request)

Ports:
- clk  in  1  clock; the block uses one clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request pending; the requester holds it, with a stable address, until req_ready.
- req_addr  in  N_REQ*MEMORY_ADDR_WIDTH  request addresses; slice i belongs to requester i.
- req_ready  out  N_REQ  one-cycle completion pulse; req_data is valid in the same cycle.
- req_data  out  N_REQ*MEMORY_WIDTH  read data; all zeros when req_ready is low.
- mem_valid  out  N_PORTS  port request.
- mem_addr  out  N_PORTS*MEMORY_ADDR_WIDTH  full address, not stripped of bank bits; all zeros when idle.
- mem_ready  in  N_PORTS  memory accepts the request and returns data in the same cycle.
- mem_data  in  N_PORTS*MEMORY_WIDTH  port read data.
- port_busy  out  N_PORTS  port is LOCKED.

## Operation
- Each port p has a state register (IDLE or LOCKED), an owner register (clog2(N_REQ) bits) and a round-robin pointer ptr[p] (same width).
- A requester is eligible for port p when all of the following hold:
  - req_valid is high;
  - it is not the owner of any LOCKED port;
  - it was not selected by a lower-numbered port in the same cycle;
  - in mode 0 only, its bank bits equal p.
- IDLE:
  - The port selects the first eligible requester scanning ptr[p], ptr[p]+1, … and wrapping modulo N_REQ.
  - If one is found, it drives mem_valid=1 and mem_addr=req_addr[sel] combinationally.
  - If mem_ready=1 in the same cycle: req_ready[sel]=1, req_data[sel]=mem_data[p], ptr[p]←(sel+1) mod N_REQ, and the port stays IDLE.
  - Otherwise: owner←sel and the port goes to LOCKED.
- LOCKED:
  - The port drives mem_valid=1 and mem_addr=req_addr[owner].
  - On mem_ready: the owner receives its req_ready pulse and data, ptr[p]←(owner+1) mod N_REQ, and the port returns to IDLE.
  - The port does not re-arbitrate in the completing cycle; it re-arbitrates in the next cycle.
- A requester that drops req_valid while it owns a port is a protocol violation. The port still completes the access and still pulses req_ready.
- A single requester is never served by two ports in the same cycle, so req_ready is at most one pulse per requester per cycle.
- Mode 1: port 0 selects first, then port 1 from the remaining requesters, and so on. With k eligible requesters and k free ports, all k are issued in the same cycle.
- Mode 0 with N_PORTS=1: PB=0 and every request goes to port 0.

## Timing
- Best-case latency is 0 cycles: request to req_ready is purely combinational through an IDLE port.
- Otherwise latency is the memory stall plus queueing behind other requesters.
- Fairness: once a requester is eligible for port p, it is served within N_REQ grants of that port.
- Reset values (while rst=1 and in the first cycle after): all ports IDLE, owner=0, ptr=0.
- While rst=1, mem_valid, req_ready and port_busy are forced to 0, and mem_addr and req_data to 0.
- Reset mid-transaction: locks are dropped. The memory must treat a mem_valid drop as cancellation, and the requester sees no req_ready.

## Test plan
- Single request, mode 0, N_PORTS=2: req 2 at addr 0x005 with mem_ready held at 1 → mem_valid[1]=1 and mem_addr=0x005 in the same cycle; req_ready[2] pulses with data 0xBEEF.
- Round-robin: reqs 0, 1 and 3 all at even addresses, mem_ready[0]=1 constantly → grants in the order 0, 1, 3, 0, …; port 1 stays idle.
- Stall/lock: req 4 is granted with mem_ready[0] low for 3 cycles; req 1 is also pending on port 0 → mem_addr stays at req 4's address, port_busy[0]=1 for 3 cycles; req 4 completes, then req 1 is granted one cycle later.
- Mode 1, 3 requesters, 2 ports, both ports ready → cycle 0 serves reqs 0 (port 0) and 1 (port 1); cycle 1 serves req 2 on port 0; no requester ever receives two req_ready pulses in one cycle.
- Reset mid-lock: port 0 LOCKED on req 3, rst pulsed for 1 cycle → mem_valid is 0 during reset; afterwards ptr=0, req 0 is granted first, and req 3 sees no req_ready from the cancelled access.

Source files
------------

// File: rtl/memory_arbiter_multiport.sv
// Round-robin arbiter connecting N_REQ memory readers to N_PORTS independent read ports.
// Each port arbitrates on its own and holds its grant (LOCKED) until the memory completes.
module memory_arbiter_multiport #(
    parameter int N_REQ             = 5,
    parameter int N_PORTS           = 2,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_WIDTH      = 16,
    parameter int PORT_MODE         = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [N_REQ*MEMORY_WIDTH-1:0]        req_data,
    output logic [N_PORTS-1:0]                   mem_valid,
    output logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] mem_addr,
    input  logic [N_PORTS-1:0]                   mem_ready,
    input  logic [N_PORTS*MEMORY_WIDTH-1:0]      mem_data,
    output logic [N_PORTS-1:0]                   port_busy
);
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int DW = MEMORY_WIDTH;
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } port_state_t;

    port_state_t      r_state     [N_PORTS];
    logic [OW-1:0]    r_owner     [N_PORTS];
    logic [OW-1:0]    r_ptr       [N_PORTS];
    port_state_t      w_state_nxt [N_PORTS];
    logic [OW-1:0]    w_owner_nxt [N_PORTS];
    logic [OW-1:0]    w_ptr_nxt   [N_PORTS];
    logic [AW-1:0]    w_req_addr  [N_REQ];
    logic [N_REQ-1:0] w_bank_ok   [N_PORTS];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_req_addr[i] = req_addr[i*AW +: AW];
    end

    // Banked mode: a request may only use the port named by its low address bits.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (PORT_MODE == 0)
                    w_bank_ok[p][i] = ((w_req_addr[i] & AW'(N_PORTS - 1)) == AW'(p));
                else
                    w_bank_ok[p][i] = 1'b1;
            end
        end
    end

    always_comb begin : arbitrate
        logic [N_REQ-1:0] w_taken;
        logic             w_found;
        int               w_sel;
        int               w_idx;
        int               w_own;

        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        req_ready = '0;
        req_data  = '0;
        mem_valid = '0;
        mem_addr  = '0;
        port_busy = '0;
        w_taken   = '0;
        w_found   = 1'b0;
        w_sel     = 0;
        w_idx     = 0;
        w_own     = 0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_state_nxt[p] = r_state[p];
            w_owner_nxt[p] = r_owner[p];
            w_ptr_nxt[p]   = r_ptr[p];
        end

        // Owners of locked ports are excluded from every port this cycle.
        for (int p = 0; p < N_PORTS; p++) begin
            if (r_state[p] == ST_LOCKED)
                w_taken[r_owner[p]] = 1'b1;
        end

        for (int p = 0; p < N_PORTS; p++) begin
            case (r_state[p])
                ST_IDLE: begin
                    w_found = 1'b0;
                    w_sel   = 0;
                    for (int k = 0; k < N_REQ; k++) begin
                        w_idx = (int'(r_ptr[p]) + k) % N_REQ;
                        if (!w_found && req_valid[w_idx] && !w_taken[w_idx] && w_bank_ok[p][w_idx]) begin
                            w_found = 1'b1;
                            w_sel   = w_idx;
                        end
                    end
                    if (w_found) begin
                        w_taken[w_sel]       = 1'b1;
                        mem_valid[p]         = 1'b1;
                        mem_addr[p*AW +: AW] = w_req_addr[w_sel];
                        if (mem_ready[p]) begin
                            req_ready[w_sel]         = 1'b1;
                            req_data[w_sel*DW +: DW] = mem_data[p*DW +: DW];
                            w_ptr_nxt[p]             = OW'((w_sel + 1) % N_REQ);
                        end else begin
                            w_owner_nxt[p] = OW'(w_sel);
                            w_state_nxt[p] = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_own                = int'(r_owner[p]);
                    mem_valid[p]         = 1'b1;
                    port_busy[p]         = 1'b1;
                    mem_addr[p*AW +: AW] = w_req_addr[w_own];
                    // Completes even if the owner dropped req_valid; re-arbitration waits a cycle.
                    if (mem_ready[p]) begin
                        req_ready[w_own]         = 1'b1;
                        req_data[w_own*DW +: DW] = mem_data[p*DW +: DW];
                        w_ptr_nxt[p]             = OW'((w_own + 1) % N_REQ);
                        w_state_nxt[p]           = ST_IDLE;
                    end
                end
                default: w_state_nxt[p] = ST_IDLE;
            endcase
        end

        if (rst) begin
            req_ready = '0;
            req_data  = '0;
            mem_valid = '0;
            mem_addr  = '0;
            port_busy = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the per-port arrays are plain
    // registers rather than a memory, so each element is reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_state[p] <= ST_IDLE;
                r_owner[p] <= '0;
                r_ptr[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_state[p] <= w_state_nxt[p];
                r_owner[p] <= w_owner_nxt[p];
                r_ptr[p]   <= w_ptr_nxt[p];
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter_multiport.sv
// Scoreboard bench: banked instance (5 req, 2 ports) and replicated instance (3 req, 2 ports).
// Stimulus pushes expected completions; negedge monitors pop them on every req_ready pulse.
module tb_memory_arbiter_multiport;
    logic clk = 1'b0;
    logic rst;

    logic [4:0]  rv0;
    logic [54:0] ra0;
    logic [4:0]  rr0;
    logic [79:0] rd0;
    logic [1:0]  mv0;
    logic [21:0] ma0;
    logic [1:0]  mr0;
    logic [31:0] md0;
    logic [1:0]  pb0;

    logic [2:0]  rv1;
    logic [32:0] ra1;
    logic [2:0]  rr1;
    logic [47:0] rd1;
    logic [1:0]  mv1;
    logic [21:0] ma1;
    logic [1:0]  mr1;
    logic [31:0] md1;
    logic [1:0]  pb1;

    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Memory model: data depends on port and address so misrouting is visible.
    function automatic logic [15:0] mem_fn(input int p, input logic [10:0] a);
        return 16'hBEEA ^ {5'b0, a} ^ ((p == 0) ? 16'h1000 : 16'h0000);
    endfunction

    assign md0 = {mem_fn(1, ma0[21:11]), mem_fn(0, ma0[10:0])};
    assign md1 = {mem_fn(1, ma1[21:11]), mem_fn(0, ma1[10:0])};

    memory_arbiter_multiport #(
        .N_REQ(5), .N_PORTS(2), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(16), .PORT_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_addr(ra0), .req_ready(rr0), .req_data(rd0),
        .mem_valid(mv0), .mem_addr(ma0), .mem_ready(mr0), .mem_data(md0),
        .port_busy(pb0)
    );

    memory_arbiter_multiport #(
        .N_REQ(3), .N_PORTS(2), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(16), .PORT_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv1), .req_addr(ra1), .req_ready(rr1), .req_data(rd1),
        .mem_valid(mv1), .mem_addr(ma1), .mem_ready(mr1), .mem_data(md1),
        .port_busy(pb1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect0(input int id, input logic [15:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        q0.push_back(e);
    endtask

    task automatic expect1(input int id, input logic [15:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        q1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (rr0[i] === 1'b1) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL m0_unexpected_ready: req %0d ready=1, expected no completion at %0t", i, $time);
                end else begin
                    e = q0.pop_front();
                    check("m0_ready_id", i, e.id);
                    check("m0_ready_data", rd0[i*16 +: 16], e.data);
                end
            end else begin
                check("m0_idle_data", rd0[i*16 +: 16], 32'h0);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rr1[i] === 1'b1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL m1_unexpected_ready: req %0d ready=1, expected no completion at %0t", i, $time);
                end else begin
                    e = q1.pop_front();
                    check("m1_ready_id", i, e.id);
                    check("m1_ready_data", rd1[i*16 +: 16], e.data);
                end
            end else begin
                check("m1_idle_data", rd1[i*16 +: 16], 32'h0);
            end
        end
    end

    initial begin
        logic [10:0] rr_addr [4];
        rr_addr = '{11'h010, 11'h020, 11'h030, 11'h010};

        rst = 1'b1;
        rv0 = '0; ra0 = '0; mr0 = '0;
        rv1 = '0; ra1 = '0; mr1 = '0;

        // Reset with a request already pending: outputs must stay quiet.
        rv0 = 5'b00100;
        ra0[2*11 +: 11] = 11'h005;
        mr0 = 2'b11;
        @(negedge clk);
        check("rst_mem_valid", mv0, 32'h0);
        check("rst_port_busy", pb0, 32'h0);
        check("rst_mem_addr", ma0, 32'h0);
        step();

        // Single request, zero-latency completion on bank 1.
        rst = 1'b0;
        expect0(2, 16'hBEEF);
        @(negedge clk);
        check("t1_mem_valid", mv0, 32'h2);
        check("t1_mem_addr1", ma0[21:11], 32'h005);
        step();
        rv0 = '0;

        // Round-robin on port 0: 0, 1, 3, 0.
        ra0[0*11 +: 11] = 11'h010;
        ra0[1*11 +: 11] = 11'h020;
        ra0[3*11 +: 11] = 11'h030;
        rv0 = 5'b01011;
        mr0 = 2'b01;
        expect0(0, mem_fn(0, 11'h010));
        expect0(1, mem_fn(0, 11'h020));
        expect0(3, mem_fn(0, 11'h030));
        expect0(0, mem_fn(0, 11'h010));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t2_mem_valid", mv0, 32'h1);
            check("t2_mem_addr0", ma0[10:0], rr_addr[c]);
            check("t2_port_busy", pb0, 32'h0);
            step();
        end
        rv0 = '0;

        // Stall: req 4 locks port 0, req 1 waits, served the cycle after completion.
        ra0[4*11 +: 11] = 11'h040;
        ra0[1*11 +: 11] = 11'h012;
        rv0 = 5'b10000;
        mr0 = 2'b00;
        expect0(4, mem_fn(0, 11'h040));
        expect0(1, mem_fn(0, 11'h012));
        @(negedge clk);
        check("t3_grant_valid", mv0, 32'h1);
        check("t3_grant_addr", ma0[10:0], 32'h040);
        check("t3_grant_busy", pb0, 32'h0);
        step();
        rv0 = 5'b10010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_lock_valid", mv0, 32'h1);
            check("t3_lock_addr", ma0[10:0], 32'h040);
            check("t3_lock_busy", pb0, 32'h1);
            step();
        end
        mr0 = 2'b01;
        @(negedge clk);
        check("t3_done_addr", ma0[10:0], 32'h040);
        check("t3_done_busy", pb0, 32'h1);
        step();
        rv0 = 5'b00010;
        @(negedge clk);
        check("t3_next_valid", mv0, 32'h1);
        check("t3_next_addr", ma0[10:0], 32'h012);
        check("t3_next_busy", pb0, 32'h0);
        step();
        rv0 = '0;

        // Reset while port 0 is locked on req 3.
        ra0[0*11 +: 11] = 11'h050;
        ra0[3*11 +: 11] = 11'h030;
        rv0 = 5'b01001;
        mr0 = 2'b00;
        @(negedge clk);
        check("t5_grant_addr", ma0[10:0], 32'h030);
        check("t5_grant_busy", pb0, 32'h0);
        step();
        @(negedge clk);
        check("t5_lock_busy", pb0, 32'h1);
        check("t5_lock_addr", ma0[10:0], 32'h030);
        step();
        rst = 1'b1;
        mr0 = 2'b01;
        @(negedge clk);
        check("t5_rst_valid", mv0, 32'h0);
        check("t5_rst_busy", pb0, 32'h0);
        check("t5_rst_addr", ma0, 32'h0);
        step();
        rst = 1'b0;
        expect0(0, mem_fn(0, 11'h050));
        @(negedge clk);
        check("t5_post_valid", mv0, 32'h1);
        check("t5_post_addr", ma0[10:0], 32'h050);
        check("t5_post_busy", pb0, 32'h0);
        step();
        rv0 = '0;
        @(negedge clk);
        check("t5_quiet_valid", mv0, 32'h0);
        step();

        // Replicated mode: two grants in one cycle, then stall on one port only.
        ra1[0*11 +: 11] = 11'h100;
        ra1[1*11 +: 11] = 11'h101;
        ra1[2*11 +: 11] = 11'h102;
        rv1 = 3'b111;
        mr1 = 2'b11;
        expect1(0, mem_fn(0, 11'h100));
        expect1(1, mem_fn(1, 11'h101));
        @(negedge clk);
        check("m1c0_valid", mv1, 32'h3);
        check("m1c0_addr0", ma1[10:0], 32'h100);
        check("m1c0_addr1", ma1[21:11], 32'h101);
        step();
        rv1 = 3'b100;
        expect1(2, mem_fn(0, 11'h102));
        @(negedge clk);
        check("m1c1_valid", mv1, 32'h1);
        check("m1c1_addr0", ma1[10:0], 32'h102);
        step();
        rv1 = 3'b011;
        mr1 = 2'b10;
        expect1(1, mem_fn(1, 11'h101));
        @(negedge clk);
        check("m1c2_valid", mv1, 32'h3);
        check("m1c2_addr0", ma1[10:0], 32'h100);
        check("m1c2_addr1", ma1[21:11], 32'h101);
        check("m1c2_busy", pb1, 32'h0);
        step();
        rv1 = 3'b001;
        mr1 = 2'b01;
        expect1(0, mem_fn(0, 11'h100));
        @(negedge clk);
        check("m1c3_valid", mv1, 32'h1);
        check("m1c3_busy", pb1, 32'h1);
        step();
        rv1 = '0;
        @(negedge clk);
        check("m1c4_valid", mv1, 32'h0);
        step();
        step();

        check("q0_drained", q0.size(), 32'h0);
        check("q1_drained", q1.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
